// File: rtl/button_debounce_pulse.sv
// Push-button front end: two-flop synchroniser, debounce FSM, and registered
// level plus single-cycle press / release / long-press / auto-repeat pulses.
module button_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse,
    output logic o_repeat_pulse
);

    localparam int MAX_DR     = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int MAX_CYCLES = (LONG_CYCLES > MAX_DR) ? LONG_CYCLES : MAX_DR;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic             REPEAT_ON = (REPEAT_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        LONG_HELD,
        RELEASE_DEB
    } state_t;

    state_t state, state_next;

    logic s1, s;
    logic [CNT_W-1:0] deb_cnt, deb_cnt_next;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_next;
    logic was_long, was_long_next;
    logic level_next, press_next, release_next, long_next, repeat_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= i_sw;
            s  <= s1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            deb_cnt         <= '0;
            hold_cnt        <= '0;
            rep_cnt         <= '0;
            was_long        <= 1'b0;
            o_level         <= 1'b0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
            o_long_pulse    <= 1'b0;
            o_repeat_pulse  <= 1'b0;
        end else begin
            state           <= state_next;
            deb_cnt         <= deb_cnt_next;
            hold_cnt        <= hold_cnt_next;
            rep_cnt         <= rep_cnt_next;
            was_long        <= was_long_next;
            o_level         <= level_next;
            o_press_pulse   <= press_next;
            o_release_pulse <= release_next;
            o_long_pulse    <= long_next;
            o_repeat_pulse  <= repeat_next;
        end
    end

    // hold_cnt and rep_cnt stay frozen in RELEASE_DEB so a rejected release bounce resumes timing
    always_comb begin
        state_next    = state;
        deb_cnt_next  = deb_cnt;
        hold_cnt_next = hold_cnt;
        rep_cnt_next  = rep_cnt;
        was_long_next = was_long;
        press_next    = 1'b0;
        release_next  = 1'b0;
        long_next     = 1'b0;
        repeat_next   = 1'b0;

        case (state)
            IDLE: begin
                if (s) begin
                    state_next   = PRESS_DEB;
                    deb_cnt_next = '0;
                end
            end
            PRESS_DEB: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next    = HELD;
                    hold_cnt_next = '0;
                    press_next    = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_next   = RELEASE_DEB;
                    deb_cnt_next = '0;
                end else if (hold_cnt == LONG_LAST) begin
                    state_next    = LONG_HELD;
                    rep_cnt_next  = '0;
                    was_long_next = 1'b1;
                    long_next     = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!s) begin
                    state_next   = RELEASE_DEB;
                    deb_cnt_next = '0;
                end else if (rep_cnt == REP_LAST) begin
                    rep_cnt_next = '0;
                    repeat_next  = REPEAT_ON;
                end else begin
                    rep_cnt_next = rep_cnt + 1'b1;
                end
            end
            RELEASE_DEB: begin
                if (s) begin
                    state_next = was_long ? LONG_HELD : HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next    = IDLE;
                    was_long_next = 1'b0;
                    release_next  = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        level_next = (state_next == HELD) || (state_next == LONG_HELD) ||
                     (state_next == RELEASE_DEB);
    end

endmodule
